// File: rtl/instruction_loader_ctrl.sv
// Loads 32-bit words from a UART byte stream into instruction memory,
// then gates pipeline execution in run or single-step mode.
module instruction_loader_ctrl #(
  parameter int          NBITS     = 32,
  parameter int          TAM       = 256,
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  input  logic              i_halt,
  output logic              o_step,
  output logic [NBITS-1:0]  o_address_memory_ins,
  output logic [NBITS-1:0]  o_instruction,
  output logic              o_write_intruc,
  output logic [ADDR_W:0]   o_loaded_count,
  output logic              o_load_full,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    READY    = 3'd5,
    RUN      = 3'd6,
    STEP     = 3'd7
  } state_t;

  localparam logic [7:0] CMD_L = 8'h4C;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [ADDR_W:0] TAM_C = (ADDR_W+1)'(TAM);

  state_t            state, next;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        idx;
  logic [31:0]       word;
  logic [31:0]       word_next;
  logic [NBITS-1:0]  instr_q;
  logic [ADDR_W:0]   loaded;
  logic              full;
  logic              rdy;
  logic              accept;
  logic              start;

  assign rdy       = (state == IDLE) || (state == LOAD) || (state == READY);
  assign accept    = i_rx_valid & rdy;
  assign cnt_inc   = cnt + 1'b1;
  assign word_next = {word[23:0], i_rx_data};

  always_comb begin
    next  = state;
    start = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && i_rx_data == CMD_L) begin
          start = 1'b1;
          next  = LOAD;
        end
      end
      LOAD: begin
        if (accept && idx == 2'd3) next = WR_SETUP;
      end
      WR_SETUP: next = WR_PULSE;
      WR_PULSE: next = WR_HOLD;
      WR_HOLD: begin
        if (word == HALT_WORD || cnt_inc == TAM_C) next = READY;
        else next = LOAD;
      end
      READY: begin
        if (accept) begin
          unique case (1'b1)
            i_rx_data == CMD_L: begin
              start = 1'b1;
              next  = LOAD;
            end
            i_rx_data == CMD_C: next = RUN;
            i_rx_data == CMD_S: next = STEP;
            default: next = READY;
          endcase
        end
      end
      RUN: begin
        if (i_halt) next = READY;
      end
      STEP: next = READY;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      idx     <= '0;
      word    <= '0;
      instr_q <= '0;
      loaded  <= '0;
      full    <= 1'b0;
    end else begin
      state <= next;
      if (start) begin
        cnt    <= '0;
        idx    <= '0;
        loaded <= '0;
        full   <= 1'b0;
      end
      if (state == LOAD && accept) begin
        word <= word_next;
        idx  <= idx + 2'd1;
        // latch address/data here so they hold steady across the strobe
        if (idx == 2'd3) begin
          addr_q  <= cnt[ADDR_W-1:0];
          instr_q <= NBITS'(word_next);
        end
      end
      if (state == WR_HOLD) begin
        cnt    <= cnt_inc;
        loaded <= cnt_inc;
        if (word != HALT_WORD && cnt_inc == TAM_C) full <= 1'b1;
      end
    end
  end

  assign o_rx_ready           = rdy & i_reset;
  assign o_step               = (state == RUN) || (state == STEP);
  assign o_write_intruc       = (state == WR_PULSE);
  assign o_address_memory_ins = NBITS'(addr_q);
  assign o_instruction        = instr_q;
  assign o_loaded_count       = loaded;
  assign o_load_full          = full;
  assign o_state              = state;

endmodule

// File: tb/tb_instruction_loader_ctrl.sv
// Directed bench for instruction_loader_ctrl: default instance plus
// a TAM=4 instance for the load-full case.
module tb_instruction_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        v1 = 1'b0, v2 = 1'b0;
  logic        halt = 1'b0;
  logic        mon_en = 1'b1;

  logic        rdy1, step1, wr1, full1;
  logic [31:0] addr1, ins1;
  logic [8:0]  cnt1;
  logic [2:0]  st1;

  logic        rdy2, step2, wr2, full2;
  logic [31:0] addr2, ins2;
  logic [2:0]  cnt2;
  logic [2:0]  st2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_loader_ctrl dut1 (
    .i_clk(clk), .i_reset(rst), .i_rx_data(data), .i_rx_valid(v1),
    .o_rx_ready(rdy1), .i_halt(halt), .o_step(step1),
    .o_address_memory_ins(addr1), .o_instruction(ins1),
    .o_write_intruc(wr1), .o_loaded_count(cnt1),
    .o_load_full(full1), .o_state(st1)
  );

  instruction_loader_ctrl #(.TAM(4), .ADDR_W(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_rx_data(data), .i_rx_valid(v2),
    .o_rx_ready(rdy2), .i_halt(1'b0), .o_step(step2),
    .o_address_memory_ins(addr2), .o_instruction(ins2),
    .o_write_intruc(wr2), .o_loaded_count(cnt2),
    .o_load_full(full2), .o_state(st2)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic [7:0] b);
    int n;
    n = 0;
    data = b;
    if (sel) v2 = 1'b1; else v1 = 1'b1;
    while (!(sel ? rdy2 : rdy1) && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("send_timeout", 64'(n), 64'd0);
    tick();
    v1 = 1'b0;
    v2 = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(sel, w[8*i +: 8]);
  endtask

  task automatic wait_ready(input bit sel);
    int n;
    n = 0;
    while ((sel ? st2 : st1) != 3'd5 && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("ready_timeout", 64'(n), 64'd0);
  endtask

  logic [31:0] qa1[$], qd1[$], qa2[$], qd2[$];
  logic [31:0] pa1, pd1, sa1, sd1;
  logic        after1 = 1'b0, pw2 = 1'b0;

  // strobe monitor for the default instance: width and stability
  always @(negedge clk) begin
    if (mon_en) begin
      if (after1) begin
        chk("hold_wr", 64'(wr1), 64'd0);
        chk("hold_addr", 64'(addr1), 64'(sa1));
        chk("hold_data", 64'(ins1), 64'(sd1));
      end
      after1 = wr1;
      if (wr1) begin
        qa1.push_back(addr1);
        qd1.push_back(ins1);
        sa1 = addr1;
        sd1 = ins1;
        chk("setup_addr", 64'(pa1), 64'(addr1));
        chk("setup_data", 64'(pd1), 64'(ins1));
      end
    end else begin
      after1 = 1'b0;
    end
    pa1 = addr1;
    pd1 = ins1;
    if (wr2) begin
      if (pw2) chk("wr2_width", 64'(pw2), 64'd0);
      qa2.push_back(addr2);
      qd2.push_back(ins2);
    end
    pw2 = wr2;
  end

  typedef struct {
    logic [7:0] b;
    int         steps;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n;
    tbl[0] = '{8'h53, 1, 3'd5};
    tbl[1] = '{8'h53, 1, 3'd5};
    tbl[2] = '{8'h53, 1, 3'd5};
    tbl[3] = '{8'h58, 0, 3'd5};
    tbl[4] = '{8'h4C, 0, 3'd1};

    rst = 1'b0;
    v1 = 1'b1;
    v2 = 1'b1;
    data = 8'h4C;
    tick();
    tick();
    @(negedge clk);
    chk("rst_state", 64'(st1), 64'd0);
    chk("rst_ready", 64'(rdy1), 64'd0);
    chk("rst_step", 64'(step1), 64'd0);
    chk("rst_wr", 64'(wr1), 64'd0);
    chk("rst_addr", 64'(addr1), 64'd0);
    chk("rst_ins", 64'(ins1), 64'd0);
    chk("rst_cnt", 64'(cnt1), 64'd0);
    chk("rst_full", 64'(full1), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    v1 = 1'b0;
    v2 = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(rdy1), 64'd1);
    tick();
    chk("post_rst_state", 64'(st1), 64'd0);

    send(0, 8'h4C);
    send_word(0, 32'h00000020);
    send_word(0, 32'hFFFFFFFF);
    wait_ready(0);
    chk("ld_strobes", 64'(qa1.size()), 64'd2);
    if (qa1.size() == 2) begin
      chk("ld_addr0", 64'(qa1[0]), 64'd0);
      chk("ld_data0", 64'(qd1[0]), 64'h20);
      chk("ld_addr1", 64'(qa1[1]), 64'd1);
      chk("ld_data1", 64'(qd1[1]), 64'hFFFFFFFF);
    end
    chk("ld_count", 64'(cnt1), 64'd2);
    chk("ld_full", 64'(full1), 64'd0);
    chk("ld_state", 64'(st1), 64'd5);

    send(0, 8'h43);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(step1);
      tick();
    end
    halt = 1'b1;
    @(negedge clk);
    n += int'(step1);
    tick();
    halt = 1'b0;
    @(negedge clk);
    chk("run_step_low", 64'(step1), 64'd0);
    chk("run_steps", 64'(n), 64'd11);
    chk("run_state", 64'(st1), 64'd5);
    tick();

    foreach (tbl[i]) begin
      send(0, tbl[i].b);
      n = 0;
      repeat (4) begin
        @(negedge clk);
        n += int'(step1);
        tick();
      end
      chk($sformatf("tbl%0d_steps", i), 64'(n), 64'(tbl[i].steps));
      chk($sformatf("tbl%0d_state", i), 64'(st1), 64'(tbl[i].st));
    end
    chk("reload_count", 64'(cnt1), 64'd0);

    qa1.delete();
    qd1.delete();
    send_word(0, 32'h12345678);
    tick();
    chk("pulse_wr", 64'(wr1), 64'd1);
    mon_en = 1'b0;
    rst = 1'b0;
    tick();
    chk("rst_pulse_wr", 64'(wr1), 64'd0);
    chk("rst_pulse_state", 64'(st1), 64'd0);
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
    qa1.delete();
    qd1.delete();
    send(0, 8'h4C);
    send_word(0, 32'hFFFFFFFF);
    wait_ready(0);
    chk("rl_strobes", 64'(qa1.size()), 64'd1);
    if (qa1.size() == 1) begin
      chk("rl_addr", 64'(qa1[0]), 64'd0);
      chk("rl_data", 64'(qd1[0]), 64'hFFFFFFFF);
    end
    chk("rl_count", 64'(cnt1), 64'd1);

    qa2.delete();
    qd2.delete();
    send(1, 8'h4C);
    for (int k = 1; k <= 5; k++) send_word(1, {4{8'(k)}});
    repeat (3) tick();
    chk("full_strobes", 64'(qa2.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < qa2.size()) begin
        chk($sformatf("full_addr%0d", k), 64'(qa2[k]), 64'(k));
        chk($sformatf("full_data%0d", k), 64'(qd2[k]),
            64'({4{8'(k + 1)}}));
      end
    end
    chk("full_flag", 64'(full2), 64'd1);
    chk("full_count", 64'(cnt2), 64'd4);
    chk("full_state", 64'(st2), 64'd5);
    chk("full_no_step", 64'(step2), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_loader_ctrl.md
Name: instruction_loader_ctrl

Overview:
Sequencer that owns the write side and step enable of the instruction memory. It accepts a byte stream from the debug UART receiver and assembles 32-bit words, MSB first. It writes these words into consecutive instruction-memory addresses using a setup/pulse/hold strobe. After loading, it gates pipeline execution in continuous-run or single-step mode, driven by command bytes.

Parameters:
NBITS, 32, instruction/address width driven to instruction memory
TAM, 256, instruction memory depth in words
ADDR_W, 8, width of internal word counter (log2 TAM)
HALT_WORD, 32'hFFFFFFFF, instruction word that terminates a load

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_reset  in  1  synchronous, active-low reset (0 = reset)
i_rx_data  in  8  received byte (command or program byte)
i_rx_valid  in  1  i_rx_data valid
o_rx_ready  out  1  byte accepted on cycle where i_rx_valid & o_rx_ready
i_halt  in  1  pipeline reports HALT instruction retired
o_step  out  1  enable to instruction fetch/pipeline for this cycle
o_address_memory_ins  out  NBITS  write word address (zero-extended counter)
o_instruction  out  NBITS  assembled word to write
o_write_intruc  out  1  write strobe; memory captures on its rising edge
o_loaded_count  out  ADDR_W+1  words written in last/current load (0..TAM)
o_load_full  out  1  load stopped because TAM words were written without HALT_WORD
o_state  out  3  current FSM state (debug)

Behaviour:
- Reset (i_reset=0 at a clock edge) sets all outputs to 0 and state to IDLE=0. This applies mid-write: o_write_intruc is 0 after that edge and the counter returns to 0.
- State encoding: IDLE=0, LOAD=1, WR_SETUP=2, WR_PULSE=3, WR_HOLD=4, READY=5, RUN=6, STEP=7. o_state is registered.
- o_rx_ready=1 only in IDLE, LOAD and READY. A byte is consumed only when valid & ready.
- Commands: 'L'=8'h4C, 'C'=8'h43, 'S'=8'h53.
- IDLE: 'L' clears counter, byte index, o_loaded_count and o_load_full, then goes to LOAD. Any other byte is consumed and ignored.
- LOAD: each byte shifts into the word register, MSB first (word = {word[23:0], byte}). The 4th byte goes to WR_SETUP.
- WR_SETUP: o_address_memory_ins = counter and o_instruction = word are driven; o_write_intruc = 0.
- WR_PULSE: o_write_intruc = 1 for exactly one cycle; address and data are unchanged.
- WR_HOLD: o_write_intruc = 0; address and data are unchanged. At exit the counter increments and o_loaded_count = counter+1. Next state:
  - READY if word == HALT_WORD (the halt word itself is written);
  - READY with o_load_full = 1 if counter+1 == TAM;
  - otherwise LOAD with byte index 0.
- Each word therefore costs 4 accepted bytes plus 3 write cycles.
- READY:
  - 'C' goes to RUN.
  - 'S' goes to STEP.
  - 'L' starts a reload: same actions as 'L' in IDLE.
  - Other bytes are ignored.
  - i_halt is ignored.
- RUN: o_step = 1 on every cycle in RUN. If i_halt = 1 is sampled in RUN, the next state is READY and o_step = 0 from that edge. Bytes are not accepted in RUN.
- STEP: o_step = 1 for exactly one cycle, then READY. If i_halt is also asserted, the result is still READY.
- o_step is registered and is 1 exactly while o_state is RUN or STEP.
- Counter wraps are not possible: the TAM limit ends the load first.
- Address output width is NBITS; the upper bits above ADDR_W are 0.

Test Plan:
- Reset held low 2 cycles, with i_rx_valid = 1 and data 'L' during reset -> all outputs 0, o_state = 0, no byte consumed; after release o_rx_ready = 1.
- Send 'L', 00 00 00 20, then FF FF FF FF -> two strobes, each exactly 1 cycle high.
  - First strobe: addr 0, data 32'h00000020.
  - Second strobe: addr 1, data 32'hFFFFFFFF.
  - Then o_loaded_count = 2, o_state = 5, o_load_full = 0.
  - Address/data are stable 1 cycle before and 1 cycle after each strobe.
- From READY send 'C', hold i_halt = 0 for 10 cycles, then pulse i_halt -> o_step high 10+1 cycles, low on the edge after i_halt, o_state = 5.
- From READY send 'S' three times -> exactly three single-cycle o_step pulses; 'X' (8'h58) -> no step, state stays 5.
- Load TAM = 4 (parameter override) with 5 non-halt words -> 4 writes at addr 0..3, o_load_full = 1, o_loaded_count = 4, READY. The 5th word's bytes are treated as commands/ignored.
- Reset asserted during WR_PULSE -> o_write_intruc = 0 next edge, state IDLE; a subsequent 'L' load starts at addr 0.
